// File: rtl/tqvp_diff_pkg.sv
// Shared constants for the tqvp_differentiator peripheral: register map,
// CTRL/STATUS bit positions, FSM state encoding and default FIFO depth.
package tqvp_diff_pkg;

  localparam logic [3:0] ADDR_CTRL      = 4'h0;
  localparam logic [3:0] ADDR_STATUS    = 4'h1;
  localparam logic [3:0] ADDR_SAMPLE_LO = 4'h2;
  localparam logic [3:0] ADDR_SAMPLE_HI = 4'h3;
  localparam logic [3:0] ADDR_HEAD_LO   = 4'h4;
  localparam logic [3:0] ADDR_HEAD_HI   = 4'h5;
  localparam logic [3:0] ADDR_POP       = 4'h6;
  localparam logic [3:0] ADDR_DEADBAND  = 4'h7;
  localparam logic [3:0] ADDR_SHIFT     = 4'h8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_SAT     = 3;
  localparam int CTRL_USE_EXT = 4;

  localparam int STAT_EMPTY  = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_PRIMED = 3;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/tqvp_differentiator_fifo.sv
// diff_fifo: small synchronous result FIFO with flush, head peek and an
// overflow pulse when a push is dropped.
module diff_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tqvp_differentiator.sv
// TinyQV first-difference peripheral: y = (x[n] - x[n-1]) >>> SHIFT with
// optional saturation, queued in diff_fifo. Optional DIFF_DEADBAND_EN.
module tqvp_differentiator
  import tqvp_diff_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        ctrl_q, lo_q, hi_q, shift_q;
  logic              ovf_q, primed_q;
  state_e            state_q, state_d;
  logic [7:0]        sync1_q, sync2_q;
  logic              strobe_q;
  logic [DATA_W-1:0] prev_q, stage_q;
  logic              stage_vld_q;

  logic [DATA_W-1:0] head, cur, res;
  logic [CW-1:0]     count;
  logic [2:0]        count3;
  logic              full, empty, fifo_ovf;
  logic              en, sat_en, use_ext;
  logic              wr_ctrl, wr_status, wr_hi, wr_pop, clear;
  logic              commit, prime_load, run_calc, suppress;
  logic signed [DATA_W:0] diff, shifted;

  assign en      = ctrl_q[CTRL_EN];
  assign sat_en  = ctrl_q[CTRL_SAT];
  assign use_ext = ctrl_q[CTRL_USE_EXT];
  assign count3  = 3'(count);

  assign wr_ctrl   = data_write && (address == ADDR_CTRL);
  assign wr_status = data_write && (address == ADDR_STATUS);
  assign wr_hi     = data_write && (address == ADDR_SAMPLE_HI);
  assign wr_pop    = data_write && (address == ADDR_POP);
  assign clear     = wr_ctrl && data_in[CTRL_CLEAR];

  // Clear wins over any commit landing in the same cycle.
  assign commit = !clear && en &&
                  (use_ext ? (sync2_q[7] && !strobe_q) : wr_hi);
  assign cur    = use_ext ? DATA_W'(sync2_q[6:0]) : DATA_W'({data_in, lo_q});
  assign prime_load = commit && (state_q == PRIME);
  assign run_calc   = commit && (state_q == RUN);

  assign diff    = $signed({cur[DATA_W-1], cur}) - $signed({prev_q[DATA_W-1], prev_q});
  assign shifted = diff >>> shift_q[3:0];

  always_comb begin
    res = shifted[DATA_W-1:0];
    if (sat_en && (shifted[DATA_W] != shifted[DATA_W-1]))
      res = shifted[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

`ifdef DIFF_DEADBAND_EN
  logic [7:0]      deadband_q;
  logic [DATA_W:0] res_ext, res_abs;
  assign res_ext  = {res[DATA_W-1], res};
  assign res_abs  = res_ext[DATA_W] ? -res_ext : res_ext;
  assign suppress = (res_abs <= (DATA_W+1)'(deadband_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      deadband_q <= '0;
    else if (data_write && address == ADDR_DEADBAND) deadband_q <= data_in;
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = data_in[CTRL_EN] ? PRIME : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_d = primed_q ? RUN : PRIME;
        PRIME:   if (!en) state_d = IDLE; else if (commit) state_d = RUN;
        RUN:     if (!en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      shift_q     <= '0;
      ovf_q       <= 1'b0;
      primed_q    <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      strobe_q    <= 1'b0;
      prev_q      <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= ui_in;
      sync2_q  <= sync1_q;
      strobe_q <= sync2_q[7];
      if (wr_ctrl) ctrl_q <= data_in & ~(8'h1 << CTRL_CLEAR);
      if (data_write && address == ADDR_SAMPLE_LO) lo_q <= data_in;
      if (wr_hi) hi_q <= data_in;
      if (data_write && address == ADDR_SHIFT) shift_q <= data_in;

      if (clear)                          ovf_q <= 1'b0;
      else if (fifo_ovf)                  ovf_q <= 1'b1;
      else if (wr_status && data_in[STAT_OVF]) ovf_q <= 1'b0;

      if (clear)           primed_q <= 1'b0;
      else if (prime_load) primed_q <= 1'b1;

      if (clear)                        prev_q <= '0;
      else if (prime_load || run_calc) prev_q <= cur;

      stage_vld_q <= run_calc && !suppress;
      if (run_calc) stage_q <= res;
    end
  end

  diff_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (stage_vld_q),
    .din   (stage_q),
    .pop   (wr_pop && !clear),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty),
    .ovf   (fifo_ovf)
  );

  assign uo_out = {ovf_q, full, ~empty, primed_q, 1'b0, count3};

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL:      data_out = ctrl_q;
      ADDR_STATUS:    data_out = {1'b0, count3, primed_q, ovf_q, full, empty};
      ADDR_SAMPLE_LO: data_out = lo_q;
      ADDR_SAMPLE_HI: data_out = hi_q;
      ADDR_HEAD_LO:   data_out = head[7:0];
      ADDR_HEAD_HI:   data_out = head[15:8];
      ADDR_POP:       data_out = {5'b0, count3};
`ifdef DIFF_DEADBAND_EN
      ADDR_DEADBAND:  data_out = deadband_q;
`endif
      ADDR_SHIFT:     data_out = shift_q;
      default:        data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_differentiator.sv
// Directed bench for tqvp_differentiator: register-mode and PMOD-mode
// differences, saturation, shift, FIFO full/overflow, clear and reset.
module tb_tqvp_differentiator;
  import tqvp_diff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  tqvp_differentiator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drivers assume they start just after a falling edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic commit(input logic [15:0] s);
    wr(ADDR_SAMPLE_LO, s[7:0]);
    wr(ADDR_SAMPLE_HI, s[15:8]);
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic chk_head(input string tag, input logic [15:0] exp);
    logic [7:0] lo, hi;
    rd(ADDR_HEAD_LO, lo);
    rd(ADDR_HEAD_HI, hi);
    check(tag, {hi, lo}, exp);
  endtask

  initial begin
    rst_n = 1'b0; ui_in = '0; address = '0; data_write = 1'b0; data_in = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    check("reset_uo_out", {8'h00, uo_out}, 16'h0000);
    chk_reg("reset_status", ADDR_STATUS, 8'h01);
    chk_reg("reset_ctrl", ADDR_CTRL, 8'h00);

    // Basic stream: 0x10 primes, then differences 0x20 and -0x10.
    wr(ADDR_CTRL, 8'h01);
    idle(2);
    commit(16'h0010);
    commit(16'h0030);
    commit(16'h0020);
    idle(1);
    chk_reg("basic_status", ADDR_STATUS, 8'h28);
    chk_head("basic_head0", 16'h0020);
    wr(ADDR_POP, 8'h00);
    chk_head("basic_head1", 16'hFFF0);
    wr(ADDR_POP, 8'h00);
    chk_reg("basic_drained", ADDR_STATUS, 8'h09);
    check("basic_uo_out", {8'h00, uo_out}, 16'h0010);

    // Saturation versus wrap on a full-scale step.
    wr(ADDR_CTRL, 8'h0B);
    commit(16'h8000);
    commit(16'h7FFF);
    idle(1);
    chk_head("sat_head", 16'h7FFF);
    chk_reg("ctrl_readback", ADDR_CTRL, 8'h09);
    wr(ADDR_CTRL, 8'h03);
    commit(16'h8000);
    commit(16'h7FFF);
    idle(1);
    chk_head("wrap_head", 16'hFFFF);
    chk_reg("wrap_count", ADDR_POP, 8'h01);

    // Arithmetic shift by 2.
    wr(ADDR_SHIFT, 8'h02);
    wr(ADDR_CTRL, 8'h03);
    commit(16'h0000);
    commit(16'hFFF0);
    idle(1);
    chk_head("shift_neg", 16'hFFFC);
    chk_reg("shift_readback", ADDR_SHIFT, 8'h02);
    wr(ADDR_CTRL, 8'h03);
    commit(16'h0000);
    commit(16'h0007);
    idle(1);
    chk_head("shift_pos", 16'h0001);
    wr(ADDR_SHIFT, 8'h00);

    // Fill past capacity: differences 1..5, the fifth is dropped.
    wr(ADDR_CTRL, 8'h03);
    commit(16'd0);
    commit(16'd1);
    commit(16'd3);
    commit(16'd6);
    commit(16'd10);
    commit(16'd15);
    idle(2);
    chk_reg("full_status", ADDR_STATUS, 8'h4E);
    chk_head("full_head", 16'h0001);
    check("full_uo_out", {8'h00, uo_out}, 16'h00F4);
    wr(ADDR_STATUS, 8'h04);
    chk_reg("ovf_cleared", ADDR_STATUS, 8'h4A);
    // Push of difference 6 lands on the same edge as the pop.
    wr(ADDR_SAMPLE_LO, 8'd21);
    wr(ADDR_SAMPLE_HI, 8'd0);
    wr(ADDR_POP, 8'h00);
    idle(1);
    chk_reg("pushpop_status", ADDR_STATUS, 8'h4A);
    chk_head("pushpop_head", 16'h0002);

    // PMOD path: 5 primes, 12 gives 7.
    wr(ADDR_CTRL, 8'h13);
    idle(1);
    ui_in = 8'h85;
    idle(6);
    ui_in = 8'h05;
    idle(4);
    ui_in = 8'h8C;
    idle(3);
    chk_reg("ext_not_yet", ADDR_STATUS, 8'h09);
    idle(2);
    chk_head("ext_head", 16'h0007);
    commit(16'h0100);
    idle(2);
    chk_reg("ext_ignores_reg", ADDR_POP, 8'h01);
    ui_in = 8'h00;
    idle(4);

    // Clear mid-stream with two entries queued.
    wr(ADDR_CTRL, 8'h03);
    commit(16'd1);
    commit(16'd2);
    commit(16'd4);
    idle(1);
    chk_reg("pre_clear_count", ADDR_POP, 8'h02);
    wr(ADDR_CTRL, 8'h03);
    chk_reg("clear_status", ADDR_STATUS, 8'h01);
    commit(16'h0050);
    idle(2);
    chk_reg("clear_prime_only", ADDR_STATUS, 8'h09);
    commit(16'h0058);
    idle(1);
    chk_head("after_clear_head", 16'h0008);

`ifdef DIFF_DEADBAND_EN
    wr(ADDR_CTRL, 8'h03);
    wr(ADDR_DEADBAND, 8'h03);
    chk_reg("deadband_readback", ADDR_DEADBAND, 8'h03);
    commit(16'h0010);
    commit(16'h0012);
    commit(16'h0016);
    idle(2);
    chk_reg("deadband_count", ADDR_POP, 8'h01);
    chk_head("deadband_head", 16'h0004);
`else
    wr(ADDR_DEADBAND, 8'h03);
    chk_reg("no_deadband_reg", ADDR_DEADBAND, 8'h00);
`endif

    // Asynchronous reset in the middle of operation.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_uo_out", {8'h00, uo_out}, 16'h0000);
    chk_reg("async_status", ADDR_STATUS, 8'h01);
    chk_reg("async_ctrl", ADDR_CTRL, 8'h00);
    chk_head("async_head", 16'h0000);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk_reg("post_reset_status", ADDR_STATUS, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
